// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt priority controller.
package irq_ctrl_pkg;

    localparam int unsigned N_LINES = 4;
    localparam int unsigned VEC_W   = 2;

    // Service sequence for one interrupt.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAck,
        StWaitRel
    } irq_state_e;

    // Fixed priority: the highest set index wins.
    function automatic logic [VEC_W-1:0] highest_index(input logic [N_LINES-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (v[i]) idx = VEC_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Multi-flop synchronizer for one asynchronous line, followed by a rising-edge detector.
module edge_sync_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw line through the synchronizer and remember the last synchronized value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A rise is a synchronized 0->1 transition; history resets to 0, so a line held high
    // through reset release is seen as exactly one edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_priority_controller.sv
// Edge-triggered interrupt controller: per-line pending flags, mask register, fixed
// highest-index priority and a request/acknowledge handshake with the CPU.
module irq_priority_controller
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LINES-1:0] irq_in,
    input  logic               mask_we,
    input  logic [N_LINES-1:0] mask_in,
    input  logic               inta,
    output logic               intr,
    output logic [VEC_W-1:0]   vec,
    output logic               vec_valid,
    output logic [N_LINES-1:0] pending
);

    logic [N_LINES-1:0] rise;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] mask_q, mask_d;
    logic [N_LINES-1:0] clr;
    logic [N_LINES-1:0] cand;
    irq_state_e         state_q, state_d;
    logic [VEC_W-1:0]   winner_q, winner_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               intr_q, intr_d;
    logic               vec_valid_q, vec_valid_d;

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        edge_sync_detect #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_edge (
            .clk (clk),
            .rst (rst),
            .d   (irq_in[i]),
            .rise(rise[i])
        );
    end

    // Pending flags: clear the served line after ACK, but a same-cycle edge wins.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_LINES; i++) begin
            clr[i] = (state_q == StAck) && (winner_q == VEC_W'(i));
        end
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_in : mask_q;
    end

    // Service FSM next state; winner is latched only on leaving IDLE and frozen afterwards.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        cand     = pending_q & ~mask_q;
        unique case (state_q)
            StIdle: begin
                if (|cand) begin
                    winner_d = highest_index(cand);
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (inta) state_d = StAck;
            end
            StAck: begin
                state_d = StWaitRel;
            end
            StWaitRel: begin
                if (!inta) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        intr_d      = (state_d == StReq);
        vec_valid_d = (state_d == StAck);
        vec_d       = vec_valid_d ? winner_d : vec_q;
    end

    // All state and outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            winner_q    <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            intr_q      <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            intr_q      <= intr_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign intr      = intr_q;
    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;
    assign pending   = pending_q;

endmodule
